dist2_sorter_ctrl: RTL



---
 rtl/dist2_sorter_pkg.sv | 21 ++
 rtl/dist2_sorter_ctrl_if.sv | 75 +++++++
 rtl/dist2_ctrl_timer.sv | 38 +++
 rtl/dist2_sorter_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/dist2_sorter_pkg.sv
// Shared types and constants for the distance-squared sorter controller.
// Holds the controller state enum, default geometry and the timer width.
package dist2_sorter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_LOAD = 2'd2,
        ST_DONE = 2'd3
    } ctrl_state_t;

    localparam int GROUPS_DEF   = 4;
    localparam int DIST_LAT_DEF = 2;
    localparam int TMR_W        = 3;

    // A one-group frame still needs a 1-bit index so ports never collapse to zero width.
    function automatic int idx_width(input int groups);
        return (groups > 1) ? $clog2(groups) : 1;
    endfunction

endpackage

// File: rtl/dist2_sorter_ctrl_if.sv
// Symbol-group handshake, dist2 operand bus, merge strobes and frame handshake
// between the sorter controller (master) and its environment (slave).
// Optional DIST2_CTRL_FLUSH_EN adds the synchronous flush request.
interface dist2_sorter_ctrl_if
    import dist2_sorter_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int GROUPS = GROUPS_DEF
);
    localparam int IDX_W = idx_width(GROUPS);

    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] inaReal;
    logic signed [WIDTH-1:0] inaImag;
    logic signed [WIDTH-1:0] inbReal;
    logic signed [WIDTH-1:0] inbImag;
    logic signed [WIDTH-1:0] incReal;
    logic signed [WIDTH-1:0] incImag;
    logic signed [WIDTH-1:0] indReal;
    logic signed [WIDTH-1:0] indImag;

    logic signed [WIDTH-1:0] dReal_a;
    logic signed [WIDTH-1:0] dImag_a;
    logic signed [WIDTH-1:0] dReal_b;
    logic signed [WIDTH-1:0] dImag_b;
    logic signed [WIDTH-1:0] dReal_c;
    logic signed [WIDTH-1:0] dImag_c;
    logic signed [WIDTH-1:0] dReal_d;
    logic signed [WIDTH-1:0] dImag_d;

    logic [GROUPS-1:0]       load;
    logic [IDX_W-1:0]        grp_idx;
    logic                    busy;
    logic                    frame_valid;
    logic                    frame_ready;
`ifdef DIST2_CTRL_FLUSH_EN
    logic                    flush;
`endif

    modport master (
`ifdef DIST2_CTRL_FLUSH_EN
        input  flush,
`endif
        input  in_valid,
        input  inaReal, inaImag, inbReal, inbImag,
        input  incReal, incImag, indReal, indImag,
        input  frame_ready,
        output in_ready,
        output dReal_a, dImag_a, dReal_b, dImag_b,
        output dReal_c, dImag_c, dReal_d, dImag_d,
        output load,
        output grp_idx,
        output busy,
        output frame_valid
    );

    modport slave (
`ifdef DIST2_CTRL_FLUSH_EN
        output flush,
`endif
        output in_valid,
        output inaReal, inaImag, inbReal, inbImag,
        output incReal, incImag, indReal, indImag,
        output frame_ready,
        input  in_ready,
        input  dReal_a, dImag_a, dReal_b, dImag_b,
        input  dReal_c, dImag_c, dReal_d, dImag_d,
        input  load,
        input  grp_idx,
        input  busy,
        input  frame_valid
    );

endinterface

// File: rtl/dist2_ctrl_timer.sv
// Loadable down-counter; expire is high while the count equals 1.
// Used to wait out a fixed datapath latency before the next sequencing step.
module dist2_ctrl_timer
    import dist2_sorter_pkg::*;
#(
    parameter int W = TMR_W
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expire
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/dist2_sorter_ctrl.sv
// Sequencer for the dist2 -> merge -> merge-bank sorter: registers one symbol
// group per handshake, strobes its merge load after DIST_LAT, then hands off the frame.
// Optional DIST2_CTRL_FLUSH_EN adds a synchronous flush that abandons the frame.
module dist2_sorter_ctrl
    import dist2_sorter_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int n        = 8,
    parameter int DIST_LAT = DIST_LAT_DEF
)(
    input  logic                 clk,
    input  logic                 rst,
    dist2_sorter_ctrl_if.master  bus
);

    localparam int GROUPS = 2 * n / 4;
    localparam int IDX_W  = idx_width(GROUPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUPS - 1);

    ctrl_state_t             state_q;
    ctrl_state_t             state_d;
    logic [IDX_W-1:0]        grp_q;
    logic [IDX_W-1:0]        grp_d;
    logic signed [WIDTH-1:0] data_q  [8];
    logic signed [WIDTH-1:0] data_d  [8];
    logic signed [WIDTH-1:0] data_in [8];

    logic capture;
    logic tmr_load;
    logic tmr_dec;
    logic tmr_expire;

    dist2_ctrl_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (TMR_W'(DIST_LAT)),
        .dec      (tmr_dec),
        .expire   (tmr_expire)
    );

    assign data_in[0] = bus.inaReal;
    assign data_in[1] = bus.inaImag;
    assign data_in[2] = bus.inbReal;
    assign data_in[3] = bus.inbImag;
    assign data_in[4] = bus.incReal;
    assign data_in[5] = bus.incImag;
    assign data_in[6] = bus.indReal;
    assign data_in[7] = bus.indImag;

    always_comb begin
        state_d  = state_q;
        grp_d    = grp_q;
        capture  = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    capture  = 1'b1;
                    tmr_load = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                tmr_dec = 1'b1;
                if (tmr_expire) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (grp_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    grp_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                    grp_d   = grp_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.frame_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef DIST2_CTRL_FLUSH_EN
        // Flush outranks both the group handshake and the frame handshake.
        if (bus.flush) begin
            state_d  = ST_IDLE;
            grp_d    = '0;
            capture  = 1'b0;
            tmr_load = 1'b0;
            tmr_dec  = 1'b0;
        end
`endif
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            data_d[i] = capture ? data_in[i] : data_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grp_q   <= '0;
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    // Ready is masked by reset so nothing is offered while the state is held.
    assign bus.in_ready    = (state_q == ST_IDLE) && !rst;
    assign bus.load        = (state_q == ST_LOAD) ? (GROUPS'(1) << grp_q) : '0;
    assign bus.grp_idx     = grp_q;
    assign bus.busy        = (state_q != ST_IDLE) || (grp_q != '0);
    assign bus.frame_valid = (state_q == ST_DONE);

    assign bus.dReal_a = data_q[0];
    assign bus.dImag_a = data_q[1];
    assign bus.dReal_b = data_q[2];
    assign bus.dImag_b = data_q[3];
    assign bus.dReal_c = data_q[4];
    assign bus.dImag_c = data_q[5];
    assign bus.dReal_d = data_q[6];
    assign bus.dImag_d = data_q[7];

endmodule
